// File: rtl/neuron_pkg.sv
// neuron_pkg: shared Q-format constants, FSM states and output saturation
package neuron_pkg;
  localparam int DATA_W = 8;
  localparam int FRAC_W = 4;
  localparam int ACC_W = 20;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - ACC_W'(1);
  typedef enum logic [1:0] {S_ACC, S_BIAS, S_OUT} state_t;
  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    return v > SAT_HI ? DATA_W'(SAT_HI) : v < SAT_LO ? DATA_W'(SAT_LO) : v[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/neuron_sat_round.sv
// neuron_sat_round: bias add, optional round-half-up (NEURON_MAC_ROUND_EN), shift and saturate
module neuron_sat_round #(
  parameter int DATA_W = neuron_pkg::DATA_W,
  parameter int FRAC_W = neuron_pkg::FRAC_W,
  parameter int ACC_W = neuron_pkg::ACC_W
) (
  input logic signed [ACC_W-1:0] acc,
  input logic signed [DATA_W-1:0] bias,
  output logic signed [DATA_W-1:0] z
);
  import neuron_pkg::*;
  logic signed [ACC_W-1:0] sum, r;
  assign sum = acc + (ACC_W'(bias) <<< FRAC_W);
`ifdef NEURON_MAC_ROUND_EN
  assign r = (sum + ACC_W'(1 << (FRAC_W-1))) >>> FRAC_W;
`else
  assign r = sum >>> FRAC_W;
`endif
  assign z = saturate(r);
endmodule

// File: rtl/neuron_mac_accumulator.sv
// neuron_mac_accumulator: serial x*w MAC plus bias to saturated Q3.4 z; NEURON_MAC_ROUND_EN selects round-half-up
module neuron_mac_accumulator #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W = neuron_pkg::DATA_W,
  parameter int FRAC_W = neuron_pkg::FRAC_W,
  parameter int ACC_W = neuron_pkg::ACC_W
) (
  input logic clk,
  input logic rst_n,
  input logic in_valid,
  output logic in_ready,
  input logic signed [DATA_W-1:0] x_in,
  input logic signed [DATA_W-1:0] w_in,
  input logic signed [DATA_W-1:0] bias,
  output logic z_valid,
  input logic z_ready,
  output logic signed [DATA_W-1:0] z_value
);
  import neuron_pkg::*;
  localparam int CNT_W = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1;
  state_t state_q, state_d;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [DATA_W-1:0] z_q, z_d, z_sat;
  logic z_valid_q, z_valid_d, last;
  assign prod = (2*DATA_W)'(x_in) * (2*DATA_W)'(w_in);
  assign last = cnt_q == CNT_W'(N_INPUTS-1);
  assign in_ready = state_q == S_ACC;
  assign z_valid = z_valid_q;
  assign z_value = z_q;
  neuron_sat_round #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_sat (
    .acc(acc_q),
    .bias(bias),
    .z(z_sat)
  );
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    z_d = z_q;
    z_valid_d = z_valid_q;
    case (state_q)
      S_ACC: if (in_valid) begin
        acc_d = acc_q + ACC_W'(prod);
        cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        state_d = last ? S_BIAS : S_ACC;
      end
      S_BIAS: begin
        z_d = z_sat;
        z_valid_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: if (z_ready) begin
        z_valid_d = 1'b0;
        acc_d = '0;
        state_d = S_ACC;
      end
      default: state_d = S_ACC;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ACC;
      acc_q <= '0;
      cnt_q <= '0;
      z_q <= '0;
      z_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      z_q <= z_d;
      z_valid_q <= z_valid_d;
    end
  end
endmodule
